logic_pod_capture_ctrl: RTL and testbench



---
 rtl/logic_pod_capture_pkg.sv | 22 ++
 rtl/logic_pod_edge_detect.sv | 32 +++
 rtl/logic_pod_capture_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_logic_pod_capture_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/logic_pod_capture_pkg.sv
// rtl/logic_pod_capture_pkg.sv - shared types and constants for the logic pod capture sequencer
package logic_pod_capture_pkg;

  localparam int SAMPLES_PER_WORD = 8;
  localparam int TIMESTAMP_BITS   = 48;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    ARMED = 3'd2,
    POST  = 3'd3,
    DONE  = 3'd4
  } capture_state_t;

  typedef enum logic [1:0] {
    RISING  = 2'd0,
    FALLING = 2'd1,
    EITHER  = 2'd2,
    HIGH    = 2'd3
  } trig_mode_t;

endpackage

// File: rtl/logic_pod_edge_detect.sv
// rtl/logic_pod_edge_detect.sv - per-word trigger match with sub-word sample position
module logic_pod_edge_detect
  import logic_pod_capture_pkg::*;
(
  input  logic [SAMPLES_PER_WORD-1:0] word,
  input  logic                        prev_bit,
  input  trig_mode_t                  mode,
  output logic                        hit,
  output logic [2:0]                  phase
);

  logic [SAMPLES_PER_WORD-1:0] pred;
  logic [SAMPLES_PER_WORD-1:0] match;

  // Compare each sample with its predecessor; sample 0 leans on the previous word's newest sample
  always_comb begin
    pred = {word[SAMPLES_PER_WORD-2:0], prev_bit};
    case (mode)
      RISING:  match = word & ~pred;
      FALLING: match = ~word & pred;
      EITHER:  match = word ^ pred;
      default: match = word;
    endcase
    hit   = |match;
    phase = 3'd0;
    // Walk downwards so the oldest matching sample is the one that sticks
    for (int i = SAMPLES_PER_WORD - 1; i >= 0; i--) begin
      if (match[i]) phase = 3'(i);
    end
  end

endmodule

// File: rtl/logic_pod_capture_ctrl.sv
// rtl/logic_pod_capture_ctrl.sv - capture sequencer (optional macro LOGIC_POD_CAPTURE_TIMESTAMP_EN)
module logic_pod_capture_ctrl
  import logic_pod_capture_pkg::*;
#(
  parameter int NUM_CHANNELS = 8,
  parameter int ADDR_BITS    = 12
) (
  input  logic                                 clk_312p5mhz,
  input  logic                                 rst_n,
  input  logic                                 arm,
  input  logic                                 abort,
  input  logic                                 force_trig,
  input  logic [ADDR_BITS-1:0]                 cfg_pre_depth,
  input  logic [ADDR_BITS-1:0]                 cfg_post_depth,
  input  logic [7:0]                           cfg_trig_chan,
  input  logic [1:0]                           cfg_trig_mode,
  input  logic [NUM_CHANNELS*SAMPLES_PER_WORD-1:0] sample_data,
  output logic                                 buf_wr_en,
  output logic [ADDR_BITS-1:0]                 buf_wr_addr,
  output logic [NUM_CHANNELS*SAMPLES_PER_WORD-1:0] buf_wr_data,
  output logic                                 busy,
  output logic                                 triggered,
  output logic                                 done,
  output logic [ADDR_BITS-1:0]                 trig_addr,
  output logic [2:0]                           trig_phase
`ifdef LOGIC_POD_CAPTURE_TIMESTAMP_EN
  ,
  output logic [TIMESTAMP_BITS-1:0]            trig_timestamp,
  output logic [TIMESTAMP_BITS-1:0]            arm_timestamp
`endif
);

  capture_state_t state, state_nx;
  logic [NUM_CHANNELS*SAMPLES_PER_WORD-1:0] s1;
  logic [NUM_CHANNELS-1:0] prev_msb;
  logic [ADDR_BITS-1:0] wr_ptr, cnt, pre_eff, post_eff, post_lim, pre_eff_in;
  logic [7:0] chan_q;
  trig_mode_t mode_q;
  logic [SAMPLES_PER_WORD-1:0] sel_word;
  logic sel_prev, chan_ok, det_hit, hit, arm_go, trig_go;
  logic [2:0] det_phase, trig_phase_nx;

  // All-ones minus post depth is just its bitwise inverse, so the pre clamp needs no subtractor
  assign post_lim   = ~cfg_post_depth;
  assign pre_eff_in = (cfg_pre_depth < post_lim) ? cfg_pre_depth : post_lim;

  assign buf_wr_en   = (state == FILL) || (state == ARMED) || (state == POST);
  assign busy        = buf_wr_en;
  assign done        = (state == DONE);
  assign buf_wr_addr = wr_ptr;
  assign buf_wr_data = s1;
  assign chan_ok     = int'(chan_q) < NUM_CHANNELS;
  assign hit         = chan_ok && det_hit;

  // Pick the trigger channel's word and its carried-in newest sample
  always_comb begin
    sel_word = '0;
    sel_prev = 1'b0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (chan_q == 8'(c)) begin
        sel_word = s1[c*SAMPLES_PER_WORD +: SAMPLES_PER_WORD];
        sel_prev = prev_msb[c];
      end
    end
  end

  logic_pod_edge_detect u_edge_detect (
    .word     (sel_word),
    .prev_bit (sel_prev),
    .mode     (mode_q),
    .hit      (det_hit),
    .phase    (det_phase)
  );

  // Sequencer next state plus arm/trigger acceptance strobes; abort overrides everything
  always_comb begin
    state_nx      = state;
    arm_go        = 1'b0;
    trig_go       = 1'b0;
    trig_phase_nx = 3'd0;
    if (abort) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (arm) begin
            arm_go   = 1'b1;
            state_nx = (pre_eff_in == '0) ? ARMED : FILL;
          end
        end
        FILL: begin
          if (force_trig) begin
            trig_go  = 1'b1;
            state_nx = (post_eff == '0) ? DONE : POST;
          end else if (cnt == pre_eff - ADDR_BITS'(1)) begin
            state_nx = ARMED;
          end
        end
        ARMED: begin
          if (hit || force_trig) begin
            trig_go       = 1'b1;
            trig_phase_nx = hit ? det_phase : 3'd0;
            state_nx      = (post_eff == '0) ? DONE : POST;
          end
        end
        POST: begin
          if (cnt == post_eff - ADDR_BITS'(1)) state_nx = DONE;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk_312p5mhz or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Sample pipeline; the newest-sample history runs regardless of state
  always_ff @(posedge clk_312p5mhz or negedge rst_n) begin
    if (!rst_n) begin
      s1       <= '0;
      prev_msb <= '0;
    end else begin
      s1 <= sample_data;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        prev_msb[c] <= s1[c*SAMPLES_PER_WORD + SAMPLES_PER_WORD - 1];
      end
    end
  end

  // Config latch, write pointer, phase counter and trigger record
  always_ff @(posedge clk_312p5mhz or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      cnt        <= '0;
      pre_eff    <= '0;
      post_eff   <= '0;
      chan_q     <= '0;
      mode_q     <= RISING;
      triggered  <= 1'b0;
      trig_addr  <= '0;
      trig_phase <= 3'd0;
    end else if (abort) begin
      triggered <= 1'b0;
    end else begin
      if (arm_go) begin
        triggered <= 1'b0;
        pre_eff   <= pre_eff_in;
        post_eff  <= cfg_post_depth;
        chan_q    <= cfg_trig_chan;
        mode_q    <= trig_mode_t'(cfg_trig_mode);
        wr_ptr    <= '0;
        cnt       <= '0;
      end else if (buf_wr_en) begin
        wr_ptr <= wr_ptr + ADDR_BITS'(1);
        cnt    <= (state_nx == state) ? cnt + ADDR_BITS'(1) : '0;
      end
      if (trig_go) begin
        triggered  <= 1'b1;
        trig_addr  <= wr_ptr;
        trig_phase <= trig_phase_nx;
      end
    end
  end

`ifdef LOGIC_POD_CAPTURE_TIMESTAMP_EN
  logic [TIMESTAMP_BITS-1:0] cycle_cnt;

  // Free-running cycle count, snapshotted at arm and at trigger
  always_ff @(posedge clk_312p5mhz or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt      <= '0;
      trig_timestamp <= '0;
      arm_timestamp  <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + TIMESTAMP_BITS'(1);
      if (arm_go)  arm_timestamp  <= cycle_cnt;
      if (trig_go) trig_timestamp <= cycle_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_logic_pod_capture_ctrl.sv
// tb/tb_logic_pod_capture_ctrl.sv - self-checking bench for logic_pod_capture_ctrl
module tb_logic_pod_capture_ctrl;

  localparam int NCH   = 8;
  localparam int AB    = 4;
  localparam int DEPTH = 16;
  localparam int MAXW  = 128;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          arm, abort, force_trig;
  logic [AB-1:0] cfg_pre_depth, cfg_post_depth;
  logic [7:0]    cfg_trig_chan;
  logic [1:0]    cfg_trig_mode;
  logic [63:0]   sample_data;
  logic          buf_wr_en, busy, triggered, done;
  logic [AB-1:0] buf_wr_addr, trig_addr;
  logic [63:0]   buf_wr_data;
  logic [2:0]    trig_phase;
`ifdef LOGIC_POD_CAPTURE_TIMESTAMP_EN
  logic [47:0]   trig_timestamp, arm_timestamp;
`endif

  int checks = 0;
  int errors = 0;

  logic [63:0]   stream [0:MAXW];
  logic [AB-1:0] wr_addr_log [$];
  logic [63:0]   wr_data_log [$];

  logic_pod_capture_ctrl #(.NUM_CHANNELS(NCH), .ADDR_BITS(AB)) dut (
    .clk_312p5mhz   (clk),
    .rst_n          (rst_n),
    .arm            (arm),
    .abort          (abort),
    .force_trig     (force_trig),
    .cfg_pre_depth  (cfg_pre_depth),
    .cfg_post_depth (cfg_post_depth),
    .cfg_trig_chan  (cfg_trig_chan),
    .cfg_trig_mode  (cfg_trig_mode),
    .sample_data    (sample_data),
    .buf_wr_en      (buf_wr_en),
    .buf_wr_addr    (buf_wr_addr),
    .buf_wr_data    (buf_wr_data),
    .busy           (busy),
    .triggered      (triggered),
    .done           (done),
    .trig_addr      (trig_addr),
    .trig_phase     (trig_phase)
`ifdef LOGIC_POD_CAPTURE_TIMESTAMP_EN
    ,
    .trig_timestamp (trig_timestamp),
    .arm_timestamp  (arm_timestamp)
`endif
  );

  always #2 clk = ~clk;

  // RAM write log, sampled mid-cycle
  always @(negedge clk) begin
    if (buf_wr_en === 1'b1) begin
      wr_addr_log.push_back(buf_wr_addr);
      wr_data_log.push_back(buf_wr_data);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: view the trigger channel as one flat sample stream; write j holds stream word j+1
  function automatic void model_trigger(input int pre_eff, input int chan, input int mode,
                                        input int force_idx, output int t, output int ph);
    bit flat [$];
    bit v, p, m;
    t  = -1;
    ph = 0;
    if (chan < NCH)
      for (int w = 0; w <= MAXW; w++)
        for (int k = 0; k < 8; k++) flat.push_back(stream[w][chan*8+k]);
    for (int j = 0; j <= MAXW - 2 && t < 0; j++) begin
      if (chan < NCH && j >= pre_eff) begin
        for (int k = 0; k < 8 && t < 0; k++) begin
          int n;
          n = (j + 1) * 8 + k;
          v = flat[n];
          p = flat[n-1];
          case (mode)
            0:       m = v & !p;
            1:       m = !v & p;
            2:       m = v ^ p;
            default: m = v;
          endcase
          if (m) begin
            t  = j;
            ph = k;
          end
        end
      end
      if (t < 0 && j == force_idx) begin
        t  = j;
        ph = 0;
      end
    end
  endfunction

  task automatic run_capture(input string tag, input int pre, input int post, input int chan,
                             input int mode, input int force_idx);
    int pre_eff, t, ph, bad, i;
    pre_eff = (pre < DEPTH - 1 - post) ? pre : DEPTH - 1 - post;
    model_trigger(pre_eff, chan, mode, force_idx, t, ph);
    wr_addr_log.delete();
    wr_data_log.delete();
    cfg_pre_depth  = AB'(pre);
    cfg_post_depth = AB'(post);
    cfg_trig_chan  = 8'(chan);
    cfg_trig_mode  = 2'(mode);
    for (i = 0; i <= MAXW; i++) begin
      sample_data = stream[i];
      arm         = (i == 1);
      force_trig  = (force_idx >= 0) && (i == force_idx + 2);
      step();
      arm        = 1'b0;
      force_trig = 1'b0;
      if (i >= 1 && done === 1'b1) break;
    end
    if (t >= 0) begin
      check({tag, " done"}, done, 1);
      check({tag, " triggered"}, triggered, 1);
      check({tag, " trig_addr"}, trig_addr, 64'(t % DEPTH));
      check({tag, " trig_phase"}, trig_phase, 64'(ph));
      check({tag, " write_count"}, wr_data_log.size(), 64'(t + 1 + post));
      bad = 0;
      foreach (wr_data_log[k])
        if (wr_data_log[k] !== stream[k+1] || wr_addr_log[k] !== AB'(k % DEPTH)) bad++;
      check({tag, " write_content"}, bad, 0);
      step();
      check({tag, " wr_en_after_done"}, buf_wr_en, 0);
      check({tag, " no_extra_writes"}, wr_data_log.size(), 64'(t + 1 + post));
    end else begin
      check({tag, " no_trigger"}, triggered, 0);
      check({tag, " still_busy"}, busy, 1);
      check({tag, " not_done"}, done, 0);
      abort = 1'b1;
      step();
      abort = 1'b0;
      check({tag, " idle_after_abort"}, busy, 0);
    end
  endtask

  task automatic randomize_stream();
    for (int i = 0; i <= MAXW; i++) stream[i] = {$urandom, $urandom};
  endtask

  initial begin
    int rpre, rpost, rchan, rmode, rforce, n_before;
    rst_n = 1'b0; arm = 1'b0; abort = 1'b0; force_trig = 1'b0;
    cfg_pre_depth = '0; cfg_post_depth = '0; cfg_trig_chan = '0; cfg_trig_mode = '0;
    sample_data = '0;
    #9;
    check("rst buf_wr_en", buf_wr_en, 0);
    check("rst buf_wr_addr", buf_wr_addr, 0);
    check("rst buf_wr_data", buf_wr_data, 0);
    check("rst busy", busy, 0);
    check("rst triggered", triggered, 0);
    check("rst done", done, 0);
    check("rst trig_addr", trig_addr, 0);
    check("rst trig_phase", trig_phase, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Basic: ch0 quiet then a rising edge at sample 4
    randomize_stream();
    for (int i = 0; i <= 10; i++) stream[i][7:0] = 8'h00;
    stream[11][7:0] = 8'h10;
    run_capture("basic", 4, 3, 0, 0, -1);

    // Falling edge carried across the word boundary
    randomize_stream();
    stream[0][7:0] = 8'h00; stream[1][7:0] = 8'h80; stream[2][7:0] = 8'h00;
    run_capture("fall_xword", 0, 2, 0, 1, -1);

    // Rising: 0x7F then 0x80 gives no boundary edge, only the in-word one at sample 7
    randomize_stream();
    stream[0][7:0] = 8'hFF; stream[1][7:0] = 8'h7F; stream[2][7:0] = 8'h80;
    run_capture("rise_xword", 0, 1, 0, 0, -1);

    // Ring wrap: trigger 40 words after the pre-fill
    randomize_stream();
    for (int i = 0; i <= 42; i++) stream[i][7:0] = 8'h00;
    stream[43][7:0] = 8'h01;
    run_capture("wrap", 2, 3, 0, 0, -1);

    // Pre depth clamped to zero by a full post depth
    randomize_stream();
    stream[1][31:24] = 8'h20;
    run_capture("clamp", 15, 15, 3, 3, -1);

    // Force in FILL with an out-of-range channel, then no force at all
    randomize_stream();
    run_capture("force_fill", 8, 2, 200, 0, 3);
    randomize_stream();
    run_capture("bad_chan", 2, 2, 200, 2, -1);

    // abort together with arm while in POST
    cfg_pre_depth = '0; cfg_post_depth = AB'(10); cfg_trig_chan = '0; cfg_trig_mode = 2'd3;
    sample_data = '1;
    arm = 1'b1;
    step();
    arm = 1'b0;
    repeat (4) step();
    check("abort pre busy", busy, 1);
    abort = 1'b1; arm = 1'b1;
    step();
    abort = 1'b0; arm = 1'b0;
    check("abort busy", busy, 0);
    check("abort wr_en", buf_wr_en, 0);
    check("abort done", done, 0);
    check("abort triggered", triggered, 0);
    n_before = wr_data_log.size();
    repeat (5) step();
    check("abort no_writes", wr_data_log.size(), 64'(n_before));
    check("abort arm_ignored", busy, 0);

    // Randomized captures against the flat-stream model
    for (int r = 0; r < 8; r++) begin
      randomize_stream();
      rpre   = $urandom_range(0, 15);
      rpost  = $urandom_range(0, 15);
      rchan  = ($urandom_range(0, 4) == 0) ? 9 : $urandom_range(0, 7);
      rmode  = $urandom_range(0, 3);
      rforce = (rchan >= NCH || $urandom_range(0, 2) == 0) ? $urandom_range(0, 30) : -1;
      run_capture("rand", rpre, rpost, rchan, rmode, rforce);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
